// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access codes, response error codes,
// FSM states and the request-classification helpers used by the control decoder.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0011,
    OP_LHU = 4'b0100,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } mem_op_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and data replication, load shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = bus_rdata >> {addr_lo, 3'b000};
    be         = 4'b0000;
    wdata_lane = 32'h0;
    load_data  = 32'h0;
    case (op)
      OP_SB: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      OP_SW: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      OP_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LW:  load_data = shifted;
      OP_LBU: load_data = {24'h0, shifted[7:0]};
      OP_LHU: load_data = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, IDLE->REQ->WAIT->RESP handshake with the bus.
// Define LSU_TIMEOUT_EN to add a bus-response watchdog of TIMEOUT_CYC cycles.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output lsu_state_e  dbg_state_o
);

  // Core side: a request transfers when req_valid_i and req_ready_o are both high on a
  // rising edge; rsp_valid_o is a single-cycle pulse that needs no acknowledgement.
  lsu_state_e  state;
  logic        ready_q, rsp_valid_q, bus_req_q, bus_act_q;
  logic [31:0] rdata_q, addr_q, wdata_q;
  logic [3:0]  op_q;
  rsp_err_e    err_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;
  logic        accept, tmo_hit;

  assign accept = (state == ST_IDLE) && ready_q && req_valid_i;

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .bus_rdata  (bus_rdata_i),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .load_data  (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                  tmo_cnt <= '0;
    else if (accept)                               tmo_cnt <= '0;
    else if (state == ST_REQ || state == ST_WAIT)  tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= ERR_OK;
      bus_req_q   <= 1'b0;
      bus_act_q   <= 1'b0;
      op_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            op_q    <= mem_op_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            ready_q <= 1'b0;
            if (!op_legal(mem_op_i)) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= ERR_ILLEGAL;
            end else if (op_misaligned(mem_op_i, addr_i[1:0])) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= ERR_MISALIGN;
            end else begin
              state     <= ST_REQ;
              bus_req_q <= 1'b1;
              bus_act_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            state     <= ST_WAIT;
            bus_req_q <= 1'b0;
          end else if (tmo_hit) begin
            state       <= ST_RESP;
            bus_req_q   <= 1'b0;
            bus_act_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= ERR_TIMEOUT;
          end
        end
        ST_WAIT: begin
          // Stores also wait here: rvalid doubles as the write acknowledge.
          if (bus_rvalid_i) begin
            state       <= ST_RESP;
            bus_act_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= load_data;
            err_q       <= ERR_OK;
          end else if (tmo_hit) begin
            state       <= ST_RESP;
            bus_act_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= ERR_TIMEOUT;
          end
        end
        default: begin
          state       <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rdata_q     <= 32'h0;
          err_q       <= ERR_OK;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // Bus attributes come from the captured request, so they stay stable while REQ waits.
  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign rsp_err_o   = err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_act_q & op_q[3];
  assign bus_addr_o  = bus_act_q ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata_o = bus_act_q ? lane_wdata : 32'h0;
  assign bus_be_o    = bus_act_q ? lane_be : 4'b0000;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; build with +define+LSU_TIMEOUT_EN to exercise the watchdog.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  mem_op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic [1:0]  rsp_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  lsu_state_e  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];

`ifdef LSU_TIMEOUT_EN
  lsu #(.TIMEOUT_CYC(4)) dut (
`else
  lsu dut (
`endif
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mem_op_i     (mem_op),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rsp_valid_o  (rsp_valid),
    .rdata_o      (rdata),
    .rsp_err_o    (rsp_err),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_be_o     (bus_be),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // scoreboard: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_spurious", {31'h0, rsp_valid}, 32'h0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check_eq("rsp_rdata", rdata, e[31:0]);
        check_eq("rsp_err", {30'h0, rsp_err}, {30'h0, e[33:32]});
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  // driver: one access; gnt_dly < 0 means the request must not reach the bus
  task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_bwd, input int gnt_dly, input logic [31:0] brd,
                        input logic [31:0] exp_rd, input logic [1:0] exp_err, input int exp_lat);
    int lat;
    wait_ready();
    exp_q.push_back({exp_err, exp_rd});
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (gnt_dly >= 0) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq("bus_req", {31'h0, bus_req}, 32'h1);
        check_eq("bus_addr", bus_addr, exp_addr);
        check_eq("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
        check_eq("bus_wdata", bus_wdata, exp_bwd);
        check_eq("bus_we", {31'h0, bus_we}, {31'h0, op[3]});
        if (i == gnt_dly) bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        lat++;
      end
      check_eq("bus_req_wait", {31'h0, bus_req}, 32'h0);
      check_eq("bus_addr_wait", bus_addr, exp_addr);
      bus_rvalid = 1'b1;
      bus_rdata  = brd;
      @(negedge clk);
      bus_rvalid = 1'b0;
      lat++;
    end else begin
      check_eq("no_bus_req", {31'h0, bus_req}, 32'h0);
    end
    while (!rsp_valid && lat < exp_lat + 8) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    @(negedge clk);
    check_eq("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    check_eq("err_idle", {30'h0, rsp_err}, 32'h0);
    check_eq("rdata_idle", rdata, 32'h0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h0);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_bus_req", {31'h0, bus_req}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // loads
    access(4'b0010, 32'h100, 32'h0, 32'h100, 4'b0000, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 3);
    access(4'b0000, 32'h103, 32'h0, 32'h100, 4'b0000, 32'h0, 1, 32'h80112233, 32'hFFFFFF80, 2'b00, 4);
    access(4'b0011, 32'h103, 32'h0, 32'h100, 4'b0000, 32'h0, 0, 32'h80112233, 32'h00000080, 2'b00, 3);
    access(4'b0100, 32'h102, 32'h0, 32'h100, 4'b0000, 32'h0, 0, 32'h80112233, 32'h00008011, 2'b00, 3);
    access(4'b0001, 32'h102, 32'h0, 32'h100, 4'b0000, 32'h0, 0, 32'h80112233, 32'hFFFF8011, 2'b00, 3);

    // stores: lane enables and replication, no load data returned
    access(4'b1001, 32'h202, 32'h0000ABCD, 32'h200, 4'b1100, 32'hABCDABCD, 0, 32'h12345678, 32'h0, 2'b00, 3);
    access(4'b1000, 32'h201, 32'h000000EF, 32'h200, 4'b0010, 32'hEFEFEFEF, 1, 32'h0, 32'h0, 2'b00, 4);

    // misaligned and illegal requests bypass the bus
    access(4'b0010, 32'h101, 32'h0, 32'h0, 4'b0000, 32'h0, -1, 32'h0, 32'h0, 2'b01, 1);
    access(4'b0110, 32'h100, 32'h0, 32'h0, 4'b0000, 32'h0, -1, 32'h0, 32'h0, 2'b10, 1);
    access(4'b1001, 32'h203, 32'h1234, 32'h0, 4'b0000, 32'h0, -1, 32'h0, 32'h0, 2'b01, 1);
    access(4'b1111, 32'h200, 32'h0, 32'h0, 4'b0000, 32'h0, -1, 32'h0, 32'h0, 2'b10, 1);

    // grant withheld for 5 cycles
`ifdef LSU_TIMEOUT_EN
    begin
      int lat;
      wait_ready();
      exp_q.push_back({2'b11, 32'h0});
      req_valid = 1'b1;
      mem_op    = 4'b1010;
      addr      = 32'h300;
      wdata     = 32'h12345678;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 12) begin
        check_eq("tmo_bus_req", {31'h0, bus_req}, 32'h1);
        check_eq("tmo_bus_addr", bus_addr, 32'h300);
        @(negedge clk);
        lat++;
      end
      check_eq("tmo_latency", lat, 5);
      check_eq("tmo_bus_req_drop", {31'h0, bus_req}, 32'h0);
      @(negedge clk);
    end
    access(4'b0010, 32'h104, 32'h0, 32'h104, 4'b0000, 32'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4);
`else
    access(4'b1010, 32'h300, 32'h12345678, 32'h300, 4'b1111, 32'h12345678, 5, 32'h0, 32'h0, 2'b00, 8);
`endif

    // reset while in WAIT abandons the store
    wait_ready();
    req_valid = 1'b1;
    mem_op    = 4'b1010;
    addr      = 32'h404;
    wdata     = 32'h5555AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    bus_gnt   = 1'b1;
    @(negedge clk);
    bus_gnt   = 1'b0;
    check_eq("in_wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    check_eq("wait_bus_we", {31'h0, bus_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", {31'h0, req_ready}, 32'h0);
    check_eq("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("arst_rdata", rdata, 32'h0);
    check_eq("arst_err", {30'h0, rsp_err}, 32'h0);
    check_eq("arst_bus_req", {31'h0, bus_req}, 32'h0);
    check_eq("arst_bus_we", {31'h0, bus_we}, 32'h0);
    check_eq("arst_bus_be", {28'h0, bus_be}, 32'h0);
    check_eq("arst_bus_addr", bus_addr, 32'h0);
    check_eq("arst_bus_wdata", bus_wdata, 32'h0);
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_arst", {31'h0, req_ready}, 32'h1);
    access(4'b0011, 32'h401, 32'h0, 32'h400, 4'b0000, 32'h0, 0, 32'h0000A500, 32'h000000A5, 2'b00, 3);

    repeat (3) @(negedge clk);
    check_eq("rsp_pending", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
